display_and_drop: RTL and testbench
===================================

DISPLAY_AND_DROP -- requirements
Module: display_and_drop

Interface
REQ-001 SHALL use one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port: clk  input  1  rising-edge system clock.
REQ-003 SHALL have port: rst_n  input  1  asynchronous active-low reset.
REQ-004 SHALL have port: t_act  input  16  actual baggage-drop time value, unsigned.
REQ-005 SHALL have port: t_lim  input  16  drop time limit, unsigned.
REQ-006 SHALL have port: drop_en  input  1  drop enable request.
REQ-007 SHALL have port: seven_seg1  output  7  leftmost display digit, segments {g,f,e,d,c,b,a}, 1 = lit.
REQ-008 SHALL have port: seven_seg2  output  7  second digit, same encoding.
REQ-009 SHALL have port: seven_seg3  output  7  third digit, same encoding.
REQ-010 SHALL have port: seven_seg4  output  7  rightmost digit, same encoding.
REQ-011 SHALL have port: drop_activated  output  1  drop actuator command.
REQ-012 SHALL have parameter: W, default 16, width of t_act/t_lim.

Function
REQ-013 SHALL compute the drop condition as drop_en AND (t_act >= t_lim), unsigned W-bit compare, no overflow possible.
REQ-014 SHALL register drop_activated from the drop condition with exactly 1 clk latency (inputs sampled at rising edge N, output valid after edge N).
REQ-015 SHALL, when the registered drop_activated is 1, drive the digits "drOP" as seg1='d' 7'h5E, seg2='r' 7'h50, seg3='o' 7'h5C, seg4='P' 7'h73.
REQ-016 SHALL, when the registered drop_activated is 0, drive the digits "COLd" as seg1='C' 7'h39, seg2='o' 7'h5C, seg3='L' 7'h38, seg4='d' 7'h5E.
REQ-017 SHALL keep the digits and drop_activated mutually consistent in every cycle (both derived from the same register).
REQ-018 SHALL treat t_act == t_lim as drop condition true.
REQ-019 SHALL treat t_lim == 0 as always satisfied; t_act == 16'hFFFF always satisfies.
REQ-020 SHALL ignore t_act/t_lim entirely while drop_en = 0 (output 0, "COLd").
REQ-021 SHALL re-evaluate every cycle; no latching: drop_activated falls 1 clk after the condition goes false.
REQ-022 SHALL have no combinational path from any input to any output.

Reset
REQ-023 SHALL, while rst_n = 0, asynchronously force drop_activated = 0 and the digits to "COLd" (7'h39,7'h5C,7'h38,7'h5E).
REQ-024 SHALL, on rst_n deassertion, resume at the first rising clk edge; reset asserted mid-drop drops the output immediately, without waiting for clk.

Structure
REQ-025 SHALL place the W default and the six segment-pattern constants (C,o,L,d,r,P) in a shared package display_and_drop_pkg.
REQ-026 SHALL implement the glyph lookup in one combinational sub-module seg_char_encoder (character code in, 7-bit pattern out), instantiated four times.
REQ-027 SHALL contain the comparator and the single state register in the top module.

Verification
REQ-028 SHALL verify reset: rst_n=0 with drop_en=1, t_act=100, t_lim=50 -> drop_activated=0, digits 39/5C/38/5E until after first edge post-release.
REQ-029 SHALL verify drop: drop_en=1, t_act=16'd200, t_lim=16'd150 -> one clk later drop_activated=1, digits 5E/50/5C/73.
REQ-030 SHALL verify equality boundary: drop_en=1, t_act=t_lim=16'hFFFF -> drop_activated=1 after 1 clk.
REQ-031 SHALL verify below limit: drop_en=1, t_act=149, t_lim=150 -> drop_activated=0, "COLd".
REQ-032 SHALL verify enable gating: drop_en=0, t_act=500, t_lim=0 -> drop_activated=0; raise drop_en -> 1 after 1 clk; lower -> 0 after 1 clk.
REQ-033 SHALL verify async reset mid-drop: while drop_activated=1, pull rst_n low between edges -> output 0 and "COLd" immediately.

Source files
------------

// File: rtl/display_and_drop_pkg.sv
// Shared constants for the baggage-drop display: default data width,
// character codes for the glyph encoder and their 7-segment patterns.
package display_and_drop_pkg;

    localparam int W_DEFAULT = 16;

    // Segment patterns, bit order {g,f,e,d,c,b,a}, 1 = lit
    localparam logic [6:0] SEG_C = 7'h39;
    localparam logic [6:0] SEG_O = 7'h5C;
    localparam logic [6:0] SEG_L = 7'h38;
    localparam logic [6:0] SEG_D = 7'h5E;
    localparam logic [6:0] SEG_R = 7'h50;
    localparam logic [6:0] SEG_P = 7'h73;

    typedef enum logic [2:0] {
        CH_C = 3'd0,
        CH_O = 3'd1,
        CH_L = 3'd2,
        CH_D = 3'd3,
        CH_R = 3'd4,
        CH_P = 3'd5
    } char_t;

endpackage

// File: rtl/seg_char_encoder.sv
// Combinational glyph lookup: character code in, 7-segment pattern out.
module seg_char_encoder
    import display_and_drop_pkg::*;
(
    input  logic [2:0] char_code,
    output logic [6:0] seg
);

    // Map character code to its segment pattern; unused codes are blank
    always_comb begin
        seg = 7'h00;
        case (char_t'(char_code))
            CH_C:    seg = SEG_C;
            CH_O:    seg = SEG_O;
            CH_L:    seg = SEG_L;
            CH_D:    seg = SEG_D;
            CH_R:    seg = SEG_R;
            CH_P:    seg = SEG_P;
            default: seg = 7'h00;
        endcase
    end

endmodule

// File: rtl/display_and_drop.sv
// Baggage-drop controller: registers drop_en && (t_act >= t_lim) and shows
// "drOP" or "COLd" on four digits. Outputs come only from the single
// drop register, so display and actuator always agree and no input reaches
// an output combinationally.
module display_and_drop
    import display_and_drop_pkg::*;
#(
    parameter int W = W_DEFAULT
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] t_act,
    input  logic [W-1:0] t_lim,
    input  logic         drop_en,
    output logic [6:0]   seven_seg1,
    output logic [6:0]   seven_seg2,
    output logic [6:0]   seven_seg3,
    output logic [6:0]   seven_seg4,
    output logic         drop_activated
);

    logic drop_d;
    logic drop_q;
    logic [2:0] char1;
    logic [2:0] char2;
    logic [2:0] char3;
    logic [2:0] char4;

    // Drop condition, re-evaluated every cycle (equality counts as reached)
    always_comb begin
        drop_d = drop_en && (t_act >= t_lim);
    end

    // Single state register; reset clears it without waiting for clk
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            drop_q <= 1'b0;
        end else begin
            drop_q <= drop_d;
        end
    end

    // Select the word to display from the registered drop state
    always_comb begin
        char1 = CH_C;
        char2 = CH_O;
        char3 = CH_L;
        char4 = CH_D;
        if (drop_q) begin
            char1 = CH_D;
            char2 = CH_R;
            char3 = CH_O;
            char4 = CH_P;
        end
    end

    assign drop_activated = drop_q;

    seg_char_encoder u_enc1 (.char_code(char1), .seg(seven_seg1));
    seg_char_encoder u_enc2 (.char_code(char2), .seg(seven_seg2));
    seg_char_encoder u_enc3 (.char_code(char3), .seg(seven_seg3));
    seg_char_encoder u_enc4 (.char_code(char4), .seg(seven_seg4));

endmodule

// File: tb/tb_display_and_drop.sv
// Bench for display_and_drop: directed scenarios plus randomized traffic,
// checked against a word-level model of the drop rule.
module tb_display_and_drop;

  // clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] t_act = '0;
  logic [15:0] t_lim = '0;
  logic        drop_en = 1'b0;
  logic [6:0]  seven_seg1, seven_seg2, seven_seg3, seven_seg4;
  logic        drop_activated;

  always #5 clk = ~clk;

  display_and_drop #(.W(16)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .t_act(t_act),
    .t_lim(t_lim),
    .drop_en(drop_en),
    .seven_seg1(seven_seg1),
    .seven_seg2(seven_seg2),
    .seven_seg3(seven_seg3),
    .seven_seg4(seven_seg4),
    .drop_activated(drop_activated)
  );

  wire [28:0] obs = {drop_activated, seven_seg1, seven_seg2, seven_seg3, seven_seg4};

  // scoreboard
  int checks = 0;
  int errors = 0;
  logic [28:0] exp_q[$];
  logic [28:0] exp_v;

  // Reference: what the panel should read for a given drop decision
  function automatic logic [28:0] panel(input bit drop);
    if (drop) return {1'b1, 7'h5E, 7'h50, 7'h5C, 7'h73}; // "drOP"
    return {1'b0, 7'h39, 7'h5C, 7'h38, 7'h5E};           // "COLd"
  endfunction

  // driver: apply inputs between edges and queue the expected next panel
  task automatic drive(input bit en, input logic [15:0] act, input logic [15:0] lim);
    drop_en = en;
    t_act = act;
    t_lim = lim;
    exp_q.push_back(panel(en && (int'(act) >= int'(lim))));
  endtask

  task automatic test_reset();
    drop_en = 1'b1; t_act = 16'd100; t_lim = 16'd50;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== panel(0)) begin errors++; $display("FAIL reset_hold0 got %h want %h", obs, panel(0)); end
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (obs !== panel(0)) begin errors++; $display("FAIL reset_hold_edges got %h want %h", obs, panel(0)); end
    rst_n = 1'b1;
    #2;
    checks++;
    if (obs !== panel(0)) begin errors++; $display("FAIL reset_release_preedge got %h want %h", obs, panel(0)); end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== panel(1)) begin errors++; $display("FAIL reset_first_edge got %h want %h", obs, panel(1)); end
  endtask

  // Fixed sequence of (en, act, lim) vectors checked one edge later
  task automatic run_vec(input string name, input bit en, input logic [15:0] act, input logic [15:0] lim);
    drive(en, act, lim);
    @(posedge clk);
    #1;
    exp_v = exp_q.pop_front();
    checks++;
    if (obs !== exp_v) begin errors++; $display("FAIL %s got %h want %h", name, obs, exp_v); end
  endtask

  task automatic test_drop();
    run_vec("drop_200_150", 1'b1, 16'd200, 16'd150);
    checks++;
    if (obs !== {1'b1, 7'h5E, 7'h50, 7'h5C, 7'h73}) begin
      errors++; $display("FAIL drop_word got %h want %h", obs, {1'b1, 7'h5E, 7'h50, 7'h5C, 7'h73});
    end
  endtask

  task automatic test_equality();
    run_vec("eq_ffff", 1'b1, 16'hFFFF, 16'hFFFF);
    run_vec("eq_mid", 1'b1, 16'd1234, 16'd1234);
    run_vec("lim_zero", 1'b1, 16'd0, 16'd0);
    run_vec("act_max", 1'b1, 16'hFFFF, 16'hFFFE);
  endtask

  task automatic test_below();
    run_vec("below_149_150", 1'b1, 16'd149, 16'd150);
    run_vec("below_0_ffff", 1'b1, 16'd0, 16'hFFFF);
  endtask

  task automatic test_enable_gating();
    run_vec("gate_off", 1'b0, 16'd500, 16'd0);
    run_vec("gate_raise", 1'b1, 16'd500, 16'd0);
    run_vec("gate_lower", 1'b0, 16'd500, 16'd0);
  endtask

  task automatic test_async_reset();
    run_vec("pre_async", 1'b1, 16'd200, 16'd150);
    #3;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs !== panel(0)) begin errors++; $display("FAIL async_reset_now got %h want %h", obs, panel(0)); end
    @(posedge clk);
    #1;
    checks++;
    if (obs !== panel(0)) begin errors++; $display("FAIL async_reset_held got %h want %h", obs, panel(0)); end
    rst_n = 1'b1;
    run_vec("post_async", 1'b1, 16'd200, 16'd150);
  endtask

  // Back-to-back random traffic with biased boundary cases
  task automatic test_random();
    logic [15:0] a, l;
    bit e;
    for (int i = 0; i < 300; i++) begin
      e = ($urandom_range(0, 3) != 0);
      a = 16'($urandom);
      case ($urandom_range(0, 5))
        0: l = a;
        1: l = 16'd0;
        2: a = 16'hFFFF;
        3: l = a + 16'd1;
        default: l = 16'($urandom);
      endcase
      if (a == 16'hFFFF && l == 16'd0) l = 16'($urandom);
      drive(e, a, l);
      @(posedge clk);
      #1;
      exp_v = exp_q.pop_front();
      checks++;
      if (obs !== exp_v) begin
        errors++;
        $display("FAIL random[%0d] en=%0b act=%h lim=%h got %h want %h", i, e, a, l, obs, exp_v);
      end
    end
  endtask

  initial begin
    test_reset();
    test_drop();
    test_equality();
    test_below();
    test_enable_gating();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // watchdog
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "timeout");
  end

endmodule
